sid_write_arbiter: RTL and testbench
====================================

# sid_write_arbiter

Shares the `tt_um_sid` register-write port between two requesters: host configuration (port A) and an on-chip note sequencer (port B). Each accepted write is replayed onto the SID bus with the standard three-phase strobe: address, voice and data set up, write strobe high for one cycle, then strobe low. Arbitration is round-robin. A per-requester lock keeps multi-register voice programming atomic, and a timeout releases an abandoned lock. The block sits between the requesters and the `ui_in[7:0]` / `uio_in` pins of the SID core.

## Interface
- `LOCK_TIMEOUT`, default 64: idle cycles tolerated from the lock owner before the lock is forcibly released; range 2..255.
- `clk` in 1: system clock, 5 MHz nominal.
- `rst` in 1: asynchronous reset, active-high.
- `a_valid` in 1: requester A has a write pending.
- `a_ready` out 1: requester A's write is accepted this cycle.
- `a_addr` in 3: requester A register address.
- `a_voice` in 2: requester A voice select.
- `a_data` in 8: requester A write data.
- `a_lock` in 1: requester A keeps the grant after this write.
- `b_valid`, `b_ready`, `b_addr`, `b_voice`, `b_data`, `b_lock`: identical set of signals for requester B.
- `sid_addr` out 3: drives SID `ui_in[2:0]`.
- `sid_voice` out 2: drives SID `ui_in[4:3]`.
- `sid_data` out 8: drives SID `uio_in`.
- `sid_we` out 1: drives SID `ui_in[7]`.
- `busy` out 1: state is not IDLE.
- `lock_owner` out 2: lock status; 00 = none, 01 = A, 10 = B.
- `lock_timeout_err` out 1: sticky flag, set on a forced lock release, cleared only by reset.
- `wr_count` out 16: number of completed strobes; wraps at 0xFFFF to 0x0000.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, HOLD.
  - IDLE → SETUP on accept.
  - SETUP → STROBE unconditionally.
  - STROBE → HOLD unconditionally.
  - HOLD → SETUP on accept, otherwise HOLD → IDLE.
- **Accept window:** a write can be accepted in IDLE or HOLD only.
  - `x_ready` is combinational: high when the state allows accept, `x_valid` = 1, and x is the granted requester.
  - An accept is `x_valid & x_ready`.
- **Grant rules, in priority order:**
  1. If `lock_owner` = x, only x can be granted, even while x_valid = 0.
  2. If only one requester is valid, it is granted.
  3. If both are valid, grant the requester that is not `last_grant`.
- **On accept:** capture addr, voice and data into the output registers, set `last_grant` = x, and update the lock.
  - `x_lock` = 1 sets `lock_owner` = x.
  - `x_lock` = 0 clears `lock_owner` if x was the owner.
- **Bus outputs:** `sid_addr`, `sid_voice` and `sid_data` hold their last captured value in every state; they never return to 0 after a write.
- **Strobe and count:** `sid_we` = 1 only in STROBE, and is registered. `wr_count` increments on the STROBE → HOLD edge.
- **Lock timeout:** a counter runs while `lock_owner` ≠ 00, state is IDLE, and the owner's valid = 0. It resets to 0 on any owner accept.
  - When it reaches `LOCK_TIMEOUT`: clear `lock_owner` and set `lock_timeout_err`.
  - Arbitration on the following cycle sees no lock.
- **Simultaneous events:** the lock is released by timeout and the owner reasserts valid in the same cycle → the release wins. The owner then re-arbitrates normally under round-robin.
- **Reset values:** state IDLE, all `sid_*` outputs 0, `busy` 0, `lock_owner` 00, `lock_timeout_err` 0, `wr_count` 0, `last_grant` = B (so A wins the first tie), timeout counter 0.
- **Reset mid-write:** asserting `rst` forces `sid_we` low immediately, without waiting for a clock edge. The in-flight write is dropped and is not counted.

## Timing
- Accept on the edge at cycle N: SETUP in cycle N+1, STROBE (`sid_we` = 1) in cycle N+2, HOLD in cycle N+3.
- Back-to-back throughput: one write every 3 cycles (the next accept occurs in HOLD).
- Addr, voice and data are stable from SETUP through HOLD: one cycle of setup and one cycle of hold around `sid_we`.
- `x_ready` is never high in SETUP or STROBE.
- Requesters must hold `x_*` stable while `x_valid` = 1 and `x_ready` = 0.
- `busy` is registered from the state and is high in SETUP, STROBE and HOLD.

## Test plan
- **Single write.** Reset, then present A with addr 0, voice 0, data 17.
  - `a_ready` = 1 in cycle 0.
  - `sid_addr`/`sid_voice`/`sid_data` = 0/0/17 from cycle 1.
  - `sid_we` = 1 only in cycle 2.
  - `wr_count` = 1 afterwards, and state returns to IDLE in cycle 4.
- **Round-robin.** Hold A and B valid continuously with 3 writes each.
  - Bus order is A, B, A, B, A, B.
  - Strobes are exactly 3 cycles apart.
  - `wr_count` = 6.
- **Lock atomicity.** A programs voice 1 with 5 writes: `a_lock` = 1 on the first 4, 0 on the last. B is valid throughout.
  - All 5 A writes appear contiguously.
  - The first B write strobes 3 cycles after A's last strobe.
  - `lock_owner` reads 01 during the burst and 00 after it.
- **Lock timeout.** A writes once with `a_lock` = 1, then drops valid; B is valid. Use `LOCK_TIMEOUT` = 8.
  - `b_ready` stays 0 for 8 IDLE cycles.
  - Then `lock_timeout_err` = 1, `lock_owner` = 00, and B is accepted on the next cycle.
- **Reset mid-write.** Assert `rst` during STROBE.
  - `sid_we` falls within the same cycle, without waiting for a clock edge.
  - All outputs read 0 and `wr_count` is unchanged at 0.
  - After release, a new A write completes normally.
- **Counter wrap.** Force 65536 strobes.
  - `wr_count` returns to 0x0000, and no other output is affected.

Source files
------------

// File: rtl/sid_write_arbiter.sv
// Round-robin arbiter sharing the SID register-write port between host (A) and
// sequencer (B); each accepted write is replayed as setup / strobe / hold.
module sid_write_arbiter #(
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [2:0] a_addr,
  input  logic [1:0] a_voice,
  input  logic [7:0] a_data,
  input  logic       a_lock,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [2:0] b_addr,
  input  logic [1:0] b_voice,
  input  logic [7:0] b_data,
  input  logic       b_lock,
  output logic [2:0] sid_addr,
  output logic [1:0] sid_voice,
  output logic [7:0] sid_data,
  output logic       sid_we,
  output logic       busy,
  output logic [1:0] lock_owner,
  output logic       lock_timeout_err,
  output logic [15:0] wr_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

  state_t      state_q;
  logic [2:0]  addr_q;
  logic [1:0]  voice_q;
  logic [7:0]  data_q;
  logic        we_q;
  logic        busy_q;
  logic [1:0]  owner_q;
  logic        err_q;
  logic [15:0] count_q;
  logic        last_b_q;
  logic [7:0]  timer_q;

  logic window;
  logic owner_valid;
  logic timer_run;
  logic expire;
  logic grant_a;
  logic grant_b;
  logic accept;

  // Handshake: x_ready is a combinational function of state, lock, last grant and
  // both valids; a write transfers on any edge where x_valid & x_ready are both high.
  always_comb begin
    window      = (state_q == S_IDLE) || (state_q == S_HOLD);
    owner_valid = ((owner_q == OWN_A) && a_valid) || ((owner_q == OWN_B) && b_valid);
    timer_run   = (owner_q != OWN_NONE) && (state_q == S_IDLE) && !owner_valid;
    // The release is keyed on the count alone, so an owner returning on the
    // final idle cycle loses the lock instead of sneaking one more write in.
    expire      = (owner_q != OWN_NONE) && (state_q == S_IDLE) && (timer_q == TIMEOUT_LAST);
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    case (owner_q)
      OWN_A:   grant_a = 1'b1;
      OWN_B:   grant_b = 1'b1;
      default: begin
        if (a_valid && b_valid) begin
          grant_a = last_b_q;
          grant_b = !last_b_q;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
    endcase
    a_ready = window && a_valid && grant_a && !expire;
    b_ready = window && b_valid && grant_b && !expire;
    accept  = a_ready || b_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 3'd0;
      voice_q  <= 2'd0;
      data_q   <= 8'd0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      count_q  <= 16'd0;
      last_b_q <= 1'b1;
      timer_q  <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_SETUP;
            busy_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q <= S_STROBE;
          we_q    <= 1'b1;
        end
        S_STROBE: begin
          state_q <= S_HOLD;
          we_q    <= 1'b0;
          count_q <= count_q + 16'd1;
        end
        default: begin
          if (accept) begin
            state_q <= S_SETUP;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase

      if (a_ready) begin
        addr_q   <= a_addr;
        voice_q  <= a_voice;
        data_q   <= a_data;
        last_b_q <= 1'b0;
        timer_q  <= 8'd0;
        if (a_lock)
          owner_q <= OWN_A;
        else if (owner_q == OWN_A)
          owner_q <= OWN_NONE;
      end else if (b_ready) begin
        addr_q   <= b_addr;
        voice_q  <= b_voice;
        data_q   <= b_data;
        last_b_q <= 1'b1;
        timer_q  <= 8'd0;
        if (b_lock)
          owner_q <= OWN_B;
        else if (owner_q == OWN_B)
          owner_q <= OWN_NONE;
      end else if (expire) begin
        owner_q <= OWN_NONE;
        err_q   <= 1'b1;
        timer_q <= 8'd0;
      end else if (timer_run) begin
        timer_q <= timer_q + 8'd1;
      end
    end
  end

  assign sid_addr         = addr_q;
  assign sid_voice        = voice_q;
  assign sid_data         = data_q;
  assign sid_we           = we_q;
  assign busy             = busy_q;
  assign lock_owner       = owner_q;
  assign lock_timeout_err = err_q;
  assign wr_count         = count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sid_write_arbiter.sv
// Directed bench for sid_write_arbiter: single write, round-robin, lock burst,
// lock timeout and its race, asynchronous reset mid-write, and counter wrap.
module tb_sid_write_arbiter;

  localparam int LOCK_TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid, a_ready, a_lock;
  logic [2:0]  a_addr;
  logic [1:0]  a_voice;
  logic [7:0]  a_data;
  logic        b_valid, b_ready, b_lock;
  logic [2:0]  b_addr;
  logic [1:0]  b_voice;
  logic [7:0]  b_data;
  logic [2:0]  sid_addr;
  logic [1:0]  sid_voice;
  logic [7:0]  sid_data;
  logic        sid_we, busy, lock_timeout_err;
  logic [1:0]  lock_owner, dbg_state;
  logic [15:0] wr_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] exp_q[$];
  logic [1:0] exp_own_q[$];
  logic [7:0] a_seq[$];
  logic [7:0] b_seq[$];
  logic       a_lock_seq[$];
  logic [7:0] obs_data[$];
  logic [1:0] obs_own[$];
  int         obs_cyc[$];

  always #5 clk = ~clk;

  sid_write_arbiter #(.LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_voice(a_voice),
    .a_data(a_data), .a_lock(a_lock),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_voice(b_voice),
    .b_data(b_data), .b_lock(b_lock),
    .sid_addr(sid_addr), .sid_voice(sid_voice), .sid_data(sid_data), .sid_we(sid_we),
    .busy(busy), .lock_owner(lock_owner), .lock_timeout_err(lock_timeout_err),
    .wr_count(wr_count), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_addr = 0; a_voice = 0; a_data = 0; a_lock = 0;
    b_valid = 0; b_addr = 0; b_voice = 0; b_data = 0; b_lock = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents a_seq/b_seq as back-to-back streams and logs every strobe.
  task automatic run_streams(input int budget);
    int  ai, bi;
    bit  acc_a, acc_b;
    ai = 0; bi = 0;
    obs_data.delete(); obs_own.delete(); obs_cyc.delete();
    for (int cyc = 0; cyc < budget; cyc++) begin
      a_valid = (ai < a_seq.size());
      if (a_valid) begin a_data = a_seq[ai]; a_lock = a_lock_seq[ai]; end
      b_valid = (bi < b_seq.size());
      if (b_valid) b_data = b_seq[bi];
      @(negedge clk);
      acc_a = a_ready;
      acc_b = b_ready;
      if (sid_we) begin
        obs_data.push_back(sid_data);
        obs_own.push_back(lock_owner);
        obs_cyc.push_back(cyc);
      end
      step();
      if (acc_a) ai++;
      if (acc_b) bi++;
    end
    a_valid = 0; b_valid = 0; a_lock = 0;
  endtask

  task automatic a_write(input logic [2:0] addr, input logic [1:0] voice,
                         input logic [7:0] data, output bit ok);
    a_addr = addr; a_voice = voice; a_data = data; a_lock = 0; a_valid = 1; ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (a_ready) ok = 1;
      step();
    end
    a_valid = 0;
    repeat (3) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vec_cnt++; if (sid_addr !== 3'd0) begin err_cnt++; $display("FAIL reset_addr: got %0h expected 0", sid_addr); end
    vec_cnt++; if (sid_data !== 8'd0) begin err_cnt++; $display("FAIL reset_data: got %0h expected 0", sid_data); end
    vec_cnt++; if (sid_we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %0b expected 0", sid_we); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vec_cnt++; if (lock_owner !== 2'b00) begin err_cnt++; $display("FAIL reset_owner: got %0b expected 00", lock_owner); end
    vec_cnt++; if (lock_timeout_err !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %0b expected 0", lock_timeout_err); end
    vec_cnt++; if (wr_count !== 16'd0) begin err_cnt++; $display("FAIL reset_count: got %0h expected 0", wr_count); end
  endtask

  task automatic test_single_write();
    do_reset();
    a_valid = 1; a_addr = 0; a_voice = 0; a_data = 8'd17;
    @(negedge clk);
    vec_cnt++; if (a_ready !== 1'b1) begin err_cnt++; $display("FAIL single_ready_c0: got %0b expected 1", a_ready); end
    step();
    a_valid = 0; a_data = 8'hEE;
    @(negedge clk);
    vec_cnt++; if (sid_data !== 8'd17) begin err_cnt++; $display("FAIL single_data_c1: got %0d expected 17", sid_data); end
    vec_cnt++; if (sid_we !== 1'b0) begin err_cnt++; $display("FAIL single_we_c1: got %0b expected 0", sid_we); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy_c1: got %0b expected 1", busy); end
    step(); @(negedge clk);
    vec_cnt++; if (sid_we !== 1'b1) begin err_cnt++; $display("FAIL single_we_c2: got %0b expected 1", sid_we); end
    step(); @(negedge clk);
    vec_cnt++; if (sid_we !== 1'b0) begin err_cnt++; $display("FAIL single_we_c3: got %0b expected 0", sid_we); end
    vec_cnt++; if (wr_count !== 16'd1) begin err_cnt++; $display("FAIL single_count: got %0d expected 1", wr_count); end
    vec_cnt++; if (sid_data !== 8'd17) begin err_cnt++; $display("FAIL single_data_hold: got %0d expected 17", sid_data); end
    step(); @(negedge clk);
    vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL single_idle_c4: got %0d expected 0", dbg_state); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_c4: got %0b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] e;
    do_reset();
    a_seq = '{8'h10, 8'h11, 8'h12};
    a_lock_seq = '{1'b0, 1'b0, 1'b0};
    b_seq = '{8'h20, 8'h21, 8'h22};
    exp_q = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    a_voice = 2'd0; b_voice = 2'd1;
    run_streams(25);
    vec_cnt++; if (obs_data.size() != 6) begin err_cnt++; $display("FAIL rr_strobes: got %0d expected 6", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      vec_cnt++; if (obs_data[i] !== e) begin err_cnt++; $display("FAIL rr_order[%0d]: got %0h expected %0h", i, obs_data[i], e); end
      if (i > 0) begin
        vec_cnt++; if (obs_cyc[i] - obs_cyc[i-1] != 3) begin err_cnt++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", i, obs_cyc[i] - obs_cyc[i-1]); end
      end
    end
    vec_cnt++; if (wr_count !== 16'd6) begin err_cnt++; $display("FAIL rr_count: got %0d expected 6", wr_count); end
  endtask

  task automatic test_lock_burst();
    logic [7:0] e;
    logic [1:0] eo;
    do_reset();
    a_seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    a_lock_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    b_seq = '{8'hB0};
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'hB0};
    exp_own_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    a_voice = 2'd1; b_voice = 2'd2;
    run_streams(25);
    vec_cnt++; if (obs_data.size() != 6) begin err_cnt++; $display("FAIL lock_strobes: got %0d expected 6", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      eo = exp_own_q.pop_front();
      vec_cnt++; if (obs_data[i] !== e) begin err_cnt++; $display("FAIL lock_order[%0d]: got %0h expected %0h", i, obs_data[i], e); end
      vec_cnt++; if (obs_own[i] !== eo) begin err_cnt++; $display("FAIL lock_owner[%0d]: got %0b expected %0b", i, obs_own[i], eo); end
      if (i > 0) begin
        vec_cnt++; if (obs_cyc[i] - obs_cyc[i-1] != 3) begin err_cnt++; $display("FAIL lock_spacing[%0d]: got %0d expected 3", i, obs_cyc[i] - obs_cyc[i-1]); end
      end
    end
    vec_cnt++; if (lock_owner !== 2'b00) begin err_cnt++; $display("FAIL lock_owner_end: got %0b expected 00", lock_owner); end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    a_valid = 1; a_lock = 1; a_addr = 3; a_voice = 2; a_data = 8'h41;
    b_valid = 1; b_addr = 5; b_voice = 1; b_data = 8'h42;
    @(negedge clk);
    vec_cnt++; if (a_ready !== 1'b1) begin err_cnt++; $display("FAIL to_a_ready: got %0b expected 1", a_ready); end
    vec_cnt++; if (b_ready !== 1'b0) begin err_cnt++; $display("FAIL to_b_ready_c0: got %0b expected 0", b_ready); end
    step();
    a_valid = 0; a_lock = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      vec_cnt++; if (b_ready !== 1'b0) begin err_cnt++; $display("FAIL to_b_blocked_c%0d: got %0b expected 0", c, b_ready); end
      if (c >= 4) begin
        vec_cnt++; if (lock_owner !== 2'b01) begin err_cnt++; $display("FAIL to_owner_c%0d: got %0b expected 01", c, lock_owner); end
        vec_cnt++; if (lock_timeout_err !== 1'b0) begin err_cnt++; $display("FAIL to_err_early_c%0d: got %0b expected 0", c, lock_timeout_err); end
      end
      step();
    end
    @(negedge clk);
    vec_cnt++; if (b_ready !== 1'b1) begin err_cnt++; $display("FAIL to_b_ready_c12: got %0b expected 1", b_ready); end
    vec_cnt++; if (lock_owner !== 2'b00) begin err_cnt++; $display("FAIL to_owner_released: got %0b expected 00", lock_owner); end
    vec_cnt++; if (lock_timeout_err !== 1'b1) begin err_cnt++; $display("FAIL to_err_set: got %0b expected 1", lock_timeout_err); end
    step();
    b_valid = 0;
    step(); @(negedge clk);
    vec_cnt++; if (sid_we !== 1'b1) begin err_cnt++; $display("FAIL to_b_strobe: got %0b expected 1", sid_we); end
    vec_cnt++; if (sid_data !== 8'h42) begin err_cnt++; $display("FAIL to_b_data: got %0h expected 42", sid_data); end
    vec_cnt++; if (sid_addr !== 3'd5) begin err_cnt++; $display("FAIL to_b_addr: got %0d expected 5", sid_addr); end
    vec_cnt++; if (lock_timeout_err !== 1'b1) begin err_cnt++; $display("FAIL to_err_sticky: got %0b expected 1", lock_timeout_err); end
  endtask

  task automatic test_timeout_race();
    do_reset();
    a_valid = 1; a_lock = 1; a_data = 8'h51;
    @(negedge clk);
    vec_cnt++; if (a_ready !== 1'b1) begin err_cnt++; $display("FAIL race_a_first: got %0b expected 1", a_ready); end
    step();
    a_valid = 0; a_lock = 0;
    repeat (10) step();
    a_valid = 1; a_data = 8'h52;
    @(negedge clk);
    vec_cnt++; if (a_ready !== 1'b0) begin err_cnt++; $display("FAIL race_release_wins: got %0b expected 0", a_ready); end
    step(); @(negedge clk);
    vec_cnt++; if (lock_owner !== 2'b00) begin err_cnt++; $display("FAIL race_owner: got %0b expected 00", lock_owner); end
    vec_cnt++; if (lock_timeout_err !== 1'b1) begin err_cnt++; $display("FAIL race_err: got %0b expected 1", lock_timeout_err); end
    vec_cnt++; if (a_ready !== 1'b1) begin err_cnt++; $display("FAIL race_rearb: got %0b expected 1", a_ready); end
    step();
    a_valid = 0;
    step(); @(negedge clk);
    vec_cnt++; if (sid_data !== 8'h52 || sid_we !== 1'b1) begin err_cnt++; $display("FAIL race_strobe: got data %0h we %0b expected 52/1", sid_data, sid_we); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    do_reset();
    a_valid = 1; a_addr = 6; a_voice = 3; a_data = 8'hC3;
    @(negedge clk);
    step();
    a_valid = 0;
    step(); @(negedge clk);
    vec_cnt++; if (sid_we !== 1'b1) begin err_cnt++; $display("FAIL rmw_in_strobe: got %0b expected 1", sid_we); end
    #1 rst = 1'b1;
    #1;
    vec_cnt++; if (sid_we !== 1'b0) begin err_cnt++; $display("FAIL rmw_we_async: got %0b expected 0", sid_we); end
    vec_cnt++; if (sid_data !== 8'd0 || sid_addr !== 3'd0 || sid_voice !== 2'd0) begin err_cnt++; $display("FAIL rmw_bus_clear: got %0h/%0d/%0d expected 0/0/0", sid_data, sid_addr, sid_voice); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmw_busy: got %0b expected 0", busy); end
    vec_cnt++; if (wr_count !== 16'd0) begin err_cnt++; $display("FAIL rmw_count: got %0d expected 0", wr_count); end
    #1 rst = 1'b0;
    step();
    a_write(3'd4, 2'd1, 8'h5A, ok);
    vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL rmw_after_accept: got %0b expected 1", ok); end
    @(negedge clk);
    vec_cnt++; if (wr_count !== 16'd1) begin err_cnt++; $display("FAIL rmw_after_count: got %0d expected 1", wr_count); end
    vec_cnt++; if (sid_data !== 8'h5A) begin err_cnt++; $display("FAIL rmw_after_data: got %0h expected 5a", sid_data); end
  endtask

  task automatic test_count_wrap();
    bit ok;
    do_reset();
    a_write(3'd2, 2'd1, 8'h33, ok);
    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    #1 release dut.count_q;
    step();
    a_write(3'd1, 2'd0, 8'h44, ok);
    @(negedge clk);
    vec_cnt++; if (wr_count !== 16'hFFFF) begin err_cnt++; $display("FAIL wrap_ffff: got %0h expected ffff", wr_count); end
    step();
    a_write(3'd7, 2'd2, 8'h55, ok);
    vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL wrap_accept: got %0b expected 1", ok); end
    @(negedge clk);
    vec_cnt++; if (wr_count !== 16'h0000) begin err_cnt++; $display("FAIL wrap_zero: got %0h expected 0000", wr_count); end
    vec_cnt++; if (sid_data !== 8'h55 || sid_addr !== 3'd7 || sid_voice !== 2'd2) begin err_cnt++; $display("FAIL wrap_bus: got %0h/%0d/%0d expected 55/7/2", sid_data, sid_addr, sid_voice); end
    vec_cnt++; if (lock_owner !== 2'b00 || lock_timeout_err !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL wrap_side: got owner %0b err %0b busy %0b expected 00/0/0", lock_owner, lock_timeout_err, busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock_burst();
    test_lock_timeout();
    test_timeout_race();
    test_reset_mid_write();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
